// File: rtl/pointer_write_memory_main.sv
// Pointer-chasing producer: builds one linked-list node per command in CoRAM
// memory (word 0 = next pointer, words 1..size-1 = payload). After each node it
// acks the control thread over the channel. A zero command ends the run and
// reports the elapsed cycle count.
module pointer_write_memory_main #(
  parameter int SIMD_WIDTH     = 1,
  parameter int LOG_SIMD_WIDTH = 0,
  parameter int W_D            = 32,
  parameter int W_A            = 12,
  parameter int W_COMM_D       = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [W_COMM_D-1:0]       comm_q,
  input  logic                      comm_empty,
  output logic                      comm_deq,
  output logic [W_COMM_D-1:0]       comm_d,
  output logic                      comm_enq,
  input  logic                      comm_full,
  output logic [W_A-1:0]            mem_addr,
  output logic [W_D*SIMD_WIDTH-1:0] mem_d,
  output logic                      mem_we,
  output logic                      busy
);

  localparam int LANES = 1 << LOG_SIMD_WIDTH;
  // Largest node that fits the address space; one bit wider than mem_addr.
  localparam logic [W_A:0] SIZE_CAP = {1'b1, {W_A{1'b0}}};

  typedef enum logic [3:0] {
    IDLE, START, CMD_DEQ, CMD_GET, PTR_DEQ, PTR_GET, WRITE, ACK, FIN
  } state_t;

  state_t                    state_q, state_d;
  logic [W_COMM_D-1:0]       node_cnt_q, node_cnt_d;
  logic [W_A:0]              size_q, size_d;
  logic [W_A:0]              wcnt_q, wcnt_d;
  logic [W_COMM_D-1:0]       ptr_q, ptr_d;
  // Cycle counter only ever leaves the block through comm_d, so it is kept at
  // channel width; the visible value is identical to a wider counter.
  logic [W_COMM_D-1:0]       cyc_q, cyc_d;
  logic                      tog_q, tog_d;
  logic                      comm_deq_q, comm_deq_d;
  logic                      comm_enq_q, comm_enq_d;
  logic [W_COMM_D-1:0]       comm_d_q, comm_d_d;
  logic [W_A-1:0]            mem_addr_q, mem_addr_d;
  logic [W_D*SIMD_WIDTH-1:0] mem_d_q, mem_d_d;
  logic                      mem_we_q, mem_we_d;
  logic [W_D*SIMD_WIDTH-1:0] wr_word;

  // Node word for the current write index: pointer in lane 0 at index 0,
  // otherwise {node, index} xor lane number in every lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [31:0]    payload;
    logic [W_D-1:0] head;
    assign payload = {node_cnt_q[15:0], 16'(wcnt_q)} ^ 32'(gi);
    if (gi == 0) begin : g_ptr
      assign head = W_D'(ptr_q);
    end else begin : g_zero
      assign head = '0;
    end
    assign wr_word[gi*W_D +: W_D] = (wcnt_q == '0) ? head : W_D'(payload);
  end

  // Next-state and next-output computation for the node builder.
  always_comb begin
    state_d    = state_q;
    node_cnt_d = node_cnt_q;
    size_d     = size_q;
    wcnt_d     = wcnt_q;
    ptr_d      = ptr_q;
    comm_d_d   = comm_d_q;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    comm_deq_d = 1'b0;
    comm_enq_d = 1'b0;
    mem_we_d   = 1'b0;

    if (state_q == IDLE) begin
      cyc_d = '0;
      tog_d = 1'b0;
    end else begin
      tog_d = ~tog_q;
      cyc_d = tog_q ? cyc_q + W_COMM_D'(1) : cyc_q;
    end

    case (state_q)
      IDLE: begin
        if (!comm_empty) begin
          comm_deq_d = 1'b1;
          node_cnt_d = '0;
          state_d    = START;
        end
      end
      START: state_d = CMD_DEQ;
      CMD_DEQ: begin
        if (!comm_empty) begin
          comm_deq_d = 1'b1;
          state_d    = CMD_GET;
        end
      end
      CMD_GET: begin
        if (comm_q == '0) begin
          state_d = FIN;
        end else begin
          size_d  = (comm_q > W_COMM_D'(SIZE_CAP)) ? SIZE_CAP : comm_q[W_A:0];
          state_d = PTR_DEQ;
        end
      end
      PTR_DEQ: begin
        if (!comm_empty) begin
          comm_deq_d = 1'b1;
          state_d    = PTR_GET;
        end
      end
      PTR_GET: begin
        ptr_d      = comm_q;
        mem_addr_d = '0;
        wcnt_d     = '0;
        state_d    = WRITE;
      end
      WRITE: begin
        // One write per cycle; the cycle after the last write moves on.
        if (wcnt_q == size_q) begin
          state_d = ACK;
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = wcnt_q[W_A-1:0];
          mem_d_d    = wr_word;
          wcnt_d     = wcnt_q + (W_A+1)'(1);
        end
      end
      ACK: begin
        if (!comm_full) begin
          comm_d_d   = node_cnt_q;
          comm_enq_d = 1'b1;
          node_cnt_d = node_cnt_q + W_COMM_D'(1);
          state_d    = CMD_DEQ;
        end
      end
      FIN: begin
        if (!comm_full) begin
          comm_d_d   = cyc_q;
          comm_enq_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any node in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      node_cnt_q <= '0;
      size_q     <= '0;
      wcnt_q     <= '0;
      ptr_q      <= '0;
      cyc_q      <= '0;
      tog_q      <= 1'b0;
      comm_deq_q <= 1'b0;
      comm_enq_q <= 1'b0;
      comm_d_q   <= '0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      node_cnt_q <= node_cnt_d;
      size_q     <= size_d;
      wcnt_q     <= wcnt_d;
      ptr_q      <= ptr_d;
      cyc_q      <= cyc_d;
      tog_q      <= tog_d;
      comm_deq_q <= comm_deq_d;
      comm_enq_q <= comm_enq_d;
      comm_d_q   <= comm_d_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign comm_deq = comm_deq_q;
  assign comm_enq = comm_enq_q;
  assign comm_d   = comm_d_q;
  assign mem_addr = mem_addr_q;
  assign mem_d    = mem_d_q;
  assign mem_we   = mem_we_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pointer_write_memory_main.sv
// Scoreboard bench: sessions of node commands are queued with their expected
// memory writes and channel acks; a negedge monitor models the channel and
// compares every write and enqueue the design presents.
module tb_pointer_write_memory_main;
  localparam int W_A = 12;
  localparam int W_D = 32;
  localparam int WC  = 32;
  localparam int CAP = 1 << W_A;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [WC-1:0] comm_q = '0;
  logic          comm_empty = 1'b1;
  logic          comm_deq;
  logic [WC-1:0] comm_d;
  logic          comm_enq;
  logic          comm_full = 1'b0;
  logic [W_A-1:0] mem_addr;
  logic [W_D-1:0] mem_d;
  logic          mem_we;
  logic          busy;

  always #5 CLK = ~CLK;

  pointer_write_memory_main #(
    .SIMD_WIDTH(1), .LOG_SIMD_WIDTH(0), .W_D(W_D), .W_A(W_A), .W_COMM_D(WC)
  ) dut (
    .CLK(CLK), .RST(RST), .comm_q(comm_q), .comm_empty(comm_empty),
    .comm_deq(comm_deq), .comm_d(comm_d), .comm_enq(comm_enq),
    .comm_full(comm_full), .mem_addr(mem_addr), .mem_d(mem_d),
    .mem_we(mem_we), .busy(busy)
  );

  // Channel contents (tag: 0 start token, 1 node command, 2 pointer, 3 end)
  logic [31:0] ch_v[$];  int ch_tag[$];
  logic [31:0] fd_v[$];  int fd_tag[$];
  // Scoreboard
  logic [W_A-1:0] exp_addr[$];
  logic [31:0]    exp_data[$];
  logic [31:0]    exp_ack[$];
  bit             exp_fin[$];
  int             exp_size[$];
  // Pending node list for the next session
  int             nd_size[$];
  logic [31:0]    nd_ptr[$];

  int checks = 0, passes = 0;
  int cyc = 0, last_deq = -10, s_cyc = 0, cmd_cyc = 0;
  bit pop_pending = 0, full_at_edge = 0, lat_check = 0, gap_mode = 0;
  int full_mode = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic add_node(input int sz, input logic [31:0] pt);
    nd_size.push_back(sz);
    nd_ptr.push_back(pt);
  endtask

  // Queue a start token, all pending nodes and the end command, plus the
  // responses the node-building rules imply.
  task automatic session();
    int i = 0;
    fd_v.push_back($urandom); fd_tag.push_back(0);
    while (nd_size.size() > 0) begin
      int sz, eff;
      logic [31:0] pt;
      sz = nd_size.pop_front();
      pt = nd_ptr.pop_front();
      eff = (sz > CAP) ? CAP : sz;
      fd_v.push_back(sz); fd_tag.push_back(1);
      fd_v.push_back(pt); fd_tag.push_back(2);
      exp_addr.push_back('0); exp_data.push_back(pt);
      for (int k = 1; k < eff; k++) begin
        exp_addr.push_back(W_A'(k));
        exp_data.push_back({i[15:0], k[15:0]});
      end
      exp_ack.push_back(i); exp_fin.push_back(1'b0); exp_size.push_back(eff);
      $display("node %0d: size %0d ptr 0x%08h, %0d writes expected", i, sz, pt, eff);
      i++;
    end
    fd_v.push_back(0); fd_tag.push_back(3);
    exp_ack.push_back(0); exp_fin.push_back(1'b1); exp_size.push_back(0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_ack.size() != 0 || exp_addr.size() != 0) && n < budget) begin
      tick(); n++;
    end
    chk(n < budget, "session_timeout", n, budget);
    repeat (2) tick();
    chk(busy == 1'b0, "idle_after_fin", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(mem_we == 0 && comm_deq == 0 && comm_enq == 0, {tag, "_strobes"},
        {mem_we, comm_deq, comm_enq}, 0);
    chk(mem_addr == 0, {tag, "_mem_addr"}, mem_addr, 0);
    chk(mem_d == 0, {tag, "_mem_d"}, mem_d, 0);
    chk(comm_d == 0, {tag, "_comm_d"}, comm_d, 0);
    chk(busy == 0, {tag, "_busy"}, busy, 0);
  endtask

  // Channel model and monitor.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      pop_pending = 0;
    end else begin
      if (pop_pending && ch_v.size() > 0) begin
        void'(ch_v.pop_front()); void'(ch_tag.pop_front());
      end
      if (comm_deq) begin
        chk(ch_v.size() > 0 && (cyc - last_deq) >= 2, "deq_legal", ch_v.size(), cyc - last_deq);
        last_deq = cyc;
        if (ch_v.size() > 0) begin
          if (ch_tag[0] == 0) s_cyc = cyc;
          else if (ch_tag[0] == 1) cmd_cyc = cyc;
        end
      end
      pop_pending = comm_deq;
      if (mem_we) begin
        if (exp_addr.size() == 0) chk(0, "unexpected_write", mem_addr, 0);
        else begin
          logic [W_A-1:0] ea;
          logic [31:0] ed;
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          chk(mem_addr == ea, "write_addr", mem_addr, ea);
          chk(mem_d == ed, "write_data", mem_d, ed);
        end
      end
      if (comm_enq) begin
        chk(!full_at_edge, "enq_while_full", full_at_edge, 0);
        if (exp_ack.size() == 0) chk(0, "unexpected_enq", comm_d, 0);
        else begin
          logic [31:0] ea;
          bit ef;
          int es;
          ea = exp_ack.pop_front();
          ef = exp_fin.pop_front();
          es = exp_size.pop_front();
          if (ef) begin
            chk(comm_d == 32'((cyc - s_cyc - 1) / 2), "fin_cyclecount", comm_d, (cyc - s_cyc - 1) / 2);
            $display("fin: cyclecount %0d", comm_d);
          end else begin
            chk(comm_d == ea, "ack_value", comm_d, ea);
            if (lat_check) chk(cyc - cmd_cyc == es + 5, "ack_latency", cyc - cmd_cyc, es + 5);
            $display("ack: node %0d", comm_d);
          end
        end
      end
    end
    // Producer side of the channel
    if (!gap_mode) begin
      while (fd_v.size() > 0) begin
        ch_v.push_back(fd_v.pop_front()); ch_tag.push_back(fd_tag.pop_front());
      end
    end else if (fd_v.size() > 0 && $urandom_range(0, 2) == 0) begin
      ch_v.push_back(fd_v.pop_front()); ch_tag.push_back(fd_tag.pop_front());
    end
    comm_full    = (full_mode == 2) ? 1'b1 : (full_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
    full_at_edge = comm_full;
    comm_empty   = (ch_v.size() == 0);
    comm_q       = comm_empty ? '0 : ch_v[0];
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check_reset_outputs("reset");
    RST = 1'b0;
    tick();

    // T1: one node of four words, pointer 0x100
    lat_check = 1;
    add_node(4, 32'h100);
    session(); wait_done(200);

    // T2: three two-word nodes
    add_node(2, 32'h40); add_node(2, 32'h80); add_node(2, 32'h0);
    session(); wait_done(200);

    // T3: pointer-only node
    add_node(1, 32'hDEAD_BEEF);
    session(); wait_done(200);

    // T4: oversize command clipped to the address space
    add_node(5000, 32'h0ABC);
    session(); wait_done(6000);

    // T5: channel full through the ack, then gaps between command and pointer
    lat_check = 0;
    full_mode = 2;
    add_node(3, 32'h55);
    session();
    repeat (25) tick();
    full_mode = 0;
    wait_done(200);
    gap_mode = 1;
    add_node(3, 32'h66); add_node(2, 32'h77);
    session(); wait_done(500);

    // Random sessions with channel stalls on both sides
    full_mode = 1;
    for (int s = 0; s < 4; s++) begin
      int nn;
      nn = $urandom_range(1, 3);
      for (int n = 0; n < nn; n++) add_node($urandom_range(1, 12), $urandom);
      session(); wait_done(1500);
    end
    full_mode = 0;
    gap_mode = 0;

    // T6: reset during a long node write
    begin
      int n = 0;
      add_node(50, 32'h77);
      session();
      while (exp_addr.size() > 40 && n < 200) begin tick(); n++; end
      chk(n < 200, "reach_write", n, 200);
      RST = 1'b1;
      tick();
      check_reset_outputs("mid_reset");
      ch_v.delete(); ch_tag.delete(); fd_v.delete(); fd_tag.delete();
      exp_addr.delete(); exp_data.delete();
      exp_ack.delete(); exp_fin.delete(); exp_size.delete();
      tick();
      RST = 1'b0;
      tick();
    end
    lat_check = 1;
    add_node(4, 32'h100);
    session(); wait_done(200);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
